rd_mem: RTL and testbench

RD_MEM -- requirements
Module: rd_mem

---
 rtl/vmem_defs.sv | 33 +++
 rtl/rd_mem.sv | 130 +++++++++++++
 tb/tb_rd_mem.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vmem_defs.sv
// vmem_defs: DRAM port definitions shared by the video memory reader and writer.
package vmem_defs;

  localparam logic [2:0] READ_CMD        = 3'd1;
  localparam logic [2:0] WRITE_CMD       = 3'd2;
  localparam logic [5:0] BRST_LEN        = 6'd63;
  localparam int         HALF_LINE_BYTES = 1024;

  localparam logic [1:0] ARB_IDLE     = 2'b00;
  localparam logic [1:0] ARB_GRANT_RD = 2'b01;
  localparam logic [1:0] ARB_GRANT_WR = 2'b10;

  localparam int ADDR_W     = 30;
  localparam int ADDR_PAD_W = 5;
  localparam int LINE_W     = 11;
  localparam int HBYTE_W    = 13;
  localparam int WCNT_W     = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FLUSH = 2'b01,
    CMD   = 2'b10,
    RDD   = 2'b11
  } rd_state_t;

  // Byte address layout: {pad, frame select, line, byte within line}
  function automatic logic [ADDR_W-1:0] pack_addr(input logic vsel,
                                                  input logic [LINE_W-1:0] line,
                                                  input logic [HBYTE_W-1:0] hbyte);
    return {{ADDR_PAD_W{1'b0}}, vsel, line, hbyte};
  endfunction

endpackage

// File: rtl/rd_mem.sv
// rd_mem: fetches one display line as two 64-word DRAM read bursts into the line buffer.
// Optional status port enabled by defining RD_MEM_DEBUG_EN.
module rd_mem
  import vmem_defs::*;
#(
  parameter int DISP_HSTART = 0,
  parameter int DISP_VSTART = 0
) (
  input  logic                cmd_clk,
  input  logic                mem_rst,
  input  logic                calib_done,
  output logic                cmd_en,
  output logic [2:0]          cmd_instr,
  output logic [5:0]          cmd_bl,
  output logic [ADDR_W-1:0]   cmd_byte_addr,
  input  logic                cmd_full,
  input  logic                cmd_empty,
  output logic                rd_en,
  input  logic [127:0]        rd_data,
  input  logic                rd_empty,
  input  logic                rd_full,
  input  logic [6:0]          rd_count,
  input  logic                req,
  input  logic [LINE_W-1:0]   req_line,
  input  logic [1:0]          req_sel,
  input  logic [1:0]          arb_state,
  output logic [127:0]        odata,
  output logic                ovalid,
  input  logic                ofull,
  output logic                done,
  output logic [7:0]          debug
);

  localparam logic [HBYTE_W-1:0] H_OFF = HBYTE_W'(DISP_HSTART * 2);
  localparam logic [LINE_W-1:0]  V_OFF = LINE_W'(DISP_VSTART);

  rd_state_t           state;
  logic [WCNT_W-1:0]   wcnt;
  logic                half;
  logic                vsel;
  logic [LINE_W-1:0]   line;
  logic [HBYTE_W-1:0]  hbyte;
  logic                unused_ok;

  assign cmd_instr = READ_CMD;
  assign cmd_bl    = BRST_LEN;
  assign odata     = rd_data;
  assign hbyte     = (half ? HBYTE_W'(HALF_LINE_BYTES) : {HBYTE_W{1'b0}}) + H_OFF;
  assign unused_ok = ^{cmd_empty, rd_full, rd_count};

  // Pops are combinational so data reaches the line buffer with zero latency
  always_comb begin
    rd_en  = 1'b0;
    ovalid = 1'b0;
    if (calib_done) begin
      case (state)
        FLUSH:   rd_en = ~rd_empty;
        RDD:     rd_en = ~rd_empty & ~ofull;
        default: rd_en = 1'b0;
      endcase
    end else begin
      rd_en = 1'b0;
    end
    ovalid = (state == RDD) & rd_en;
  end

  // Line fetch sequencer: flush stale data, issue two bursts, count delivered words
  always_ff @(posedge cmd_clk) begin
    if (mem_rst) begin
      state         <= IDLE;
      cmd_en        <= 1'b0;
      done          <= 1'b0;
      wcnt          <= {WCNT_W{1'b0}};
      half          <= 1'b0;
      line          <= {LINE_W{1'b0}};
      vsel          <= 1'b0;
      cmd_byte_addr <= {ADDR_W{1'b0}};
    end else if (!calib_done) begin
      cmd_en <= 1'b0;
      done   <= 1'b0;
    end else begin
      cmd_en <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            line  <= req_line + V_OFF;
            vsel  <= (req_sel == 2'd1) ? 1'b0 : 1'b1;
            half  <= 1'b0;
            state <= rd_empty ? CMD : FLUSH;
          end
        end
        FLUSH: begin
          if (rd_empty) state <= CMD;
        end
        CMD: begin
          if (!cmd_full && (arb_state == ARB_GRANT_RD)) begin
            cmd_en        <= 1'b1;
            wcnt          <= {WCNT_W{1'b0}};
            cmd_byte_addr <= pack_addr(vsel, line, hbyte);
            state         <= RDD;
          end
        end
        RDD: begin
          if (rd_en) begin
            wcnt <= wcnt + 7'd1;
            // Last word of this burst: either fetch the second half or finish the line
            if (wcnt == {1'b0, BRST_LEN}) begin
              if (!half) begin
                half  <= 1'b1;
                state <= CMD;
              end else begin
                done  <= 1'b1;
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RD_MEM_DEBUG_EN
  assign debug = {ofull, rd_empty, cmd_full, rd_en, half, vsel, state};
`else
  assign debug = 8'd0;
`endif

endmodule

// File: tb/tb_rd_mem.sv
// tb_rd_mem: directed bench with a FIFO/DRAM environment model and per-cycle scoreboard.
module tb_rd_mem;

  localparam int HS1 = 64;
  localparam int VS1 = 3;

  logic cmd_clk = 1'b0;
  always #5 cmd_clk = ~cmd_clk;

  logic         mem_rst, calib_done, cmd_full, cmd_empty, rd_empty, rd_full, req, ofull;
  logic [127:0] rd_data;
  logic [6:0]   rd_count;
  logic [10:0]  req_line;
  logic [1:0]   req_sel, arb_state;

  logic         cmd_en0, rd_en0, ovalid0, done0, cmd_en1, rd_en1, ovalid1, done1;
  logic [2:0]   instr0, instr1;
  logic [5:0]   bl0, bl1;
  logic [29:0]  addr0, addr1;
  logic [127:0] odata0, odata1;
  logic [7:0]   debug0, debug1;

  rd_mem dut0 (
    .cmd_clk(cmd_clk), .mem_rst(mem_rst), .calib_done(calib_done),
    .cmd_en(cmd_en0), .cmd_instr(instr0), .cmd_bl(bl0), .cmd_byte_addr(addr0),
    .cmd_full(cmd_full), .cmd_empty(cmd_empty), .rd_en(rd_en0), .rd_data(rd_data),
    .rd_empty(rd_empty), .rd_full(rd_full), .rd_count(rd_count), .req(req),
    .req_line(req_line), .req_sel(req_sel), .arb_state(arb_state), .odata(odata0),
    .ovalid(ovalid0), .ofull(ofull), .done(done0), .debug(debug0)
  );

  rd_mem #(.DISP_HSTART(HS1), .DISP_VSTART(VS1)) dut1 (
    .cmd_clk(cmd_clk), .mem_rst(mem_rst), .calib_done(calib_done),
    .cmd_en(cmd_en1), .cmd_instr(instr1), .cmd_bl(bl1), .cmd_byte_addr(addr1),
    .cmd_full(cmd_full), .cmd_empty(cmd_empty), .rd_en(rd_en1), .rd_data(rd_data),
    .rd_empty(rd_empty), .rd_full(rd_full), .rd_count(rd_count), .req(req),
    .req_line(req_line), .req_sel(req_sel), .arb_state(arb_state), .odata(odata1),
    .ovalid(ovalid1), .ofull(ofull), .done(done1), .debug(debug1)
  );

  logic [127:0] fifo[$];
  logic [127:0] exp_beats[$];
  logic [29:0]  exp_addr0[$], exp_addr1[$], log0[$], log1[$];

  int checks = 0, errors = 0, cyc = 0, epoch = 1;
  int gen_left = 0, gen_epoch = 0, gen_cmd = 0, gen_idx = 0;
  int beats_line = 0, done_count = 0, cmd_count = 0, flush_pops = 0;
  int rst_hold = 0, rst_at_beat = 0;
  bit ofull_mode = 1'b0, prev_cmd_en = 1'b0, calib_cfg = 1'b1;

  task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Address a line half must use, straight from the address layout rules
  function automatic logic [29:0] model_addr(input int sel, input int rline, input int half,
                                             input int hstart, input int vstart);
    int vs = (sel == 1) ? 0 : 1;
    int ln = (rline + vstart) % 2048;
    int hb = (half * 1024 + hstart * 2) % 8192;
    return 30'(vs * (1 << 24) + ln * (1 << 13) + hb);
  endfunction

  task automatic compare();
    logic [127:0] w;
    check(rd_en1 == rd_en0 && ovalid1 == ovalid0 && cmd_en1 == cmd_en0 && done1 == done0,
          "lockstep", {rd_en1, ovalid1, cmd_en1, done1}, {rd_en0, ovalid0, cmd_en0, done0});
    check(!(rd_en0 && rd_empty), "rd_underflow", rd_en0, 0);
    check(!(rd_en0 && ofull && ofull_mode), "rd_en_while_ofull", rd_en0, 0);
    check(!(ovalid0 && !rd_en0), "ovalid_without_pop", ovalid0, rd_en0);
    check(!(cmd_en0 && prev_cmd_en), "cmd_en_single_pulse", cmd_en0, 0);
    if (!calib_done) check(!rd_en0 && !cmd_en0, "calib_low_strobes", {rd_en0, cmd_en0}, 0);
    prev_cmd_en = cmd_en0;
    if (rd_en0 && !rd_empty) begin
      w = fifo.pop_front();
      if (ovalid0) begin
        check(odata0 == w, "odata_is_fifo_head", odata0, w);
        check(exp_beats.size() != 0, "beat_expected", w, 0);
        if (exp_beats.size() != 0) check(w == exp_beats[0], "beat_order", w, exp_beats[0]);
        if (exp_beats.size() != 0) void'(exp_beats.pop_front());
        beats_line++;
      end else begin
        check(w[127:96] != 32'(epoch), "flush_pops_stale_only", w[127:96], epoch);
        flush_pops++;
      end
    end
    if (cmd_en0) begin
      cmd_count++;
      log0.push_back(addr0);
      log1.push_back(addr1);
      check(exp_addr0.size() != 0, "cmd_expected", addr0, 0);
      if (exp_addr0.size() != 0) check(addr0 == exp_addr0[0], "cmd_addr0", addr0, exp_addr0[0]);
      if (exp_addr1.size() != 0) check(addr1 == exp_addr1[0], "cmd_addr1", addr1, exp_addr1[0]);
      if (exp_addr0.size() != 0) void'(exp_addr0.pop_front());
      if (exp_addr1.size() != 0) void'(exp_addr1.pop_front());
      check(instr0 == 3'd1 && bl0 == 6'd63, "cmd_consts", {instr0, bl0}, {3'd1, 6'd63});
      gen_left = 64; gen_epoch = epoch; gen_cmd = cmd_count; gen_idx = 0;
    end
    if (done0) begin
      done_count++;
      check(beats_line == 128, "beats_per_line", beats_line, 128);
      check(exp_beats.size() == 0, "line_drained", exp_beats.size(), 0);
      beats_line = 0;
    end
    if (rst_at_beat != 0 && beats_line == rst_at_beat) begin
      mem_rst = 1'b1; rst_hold = 3; rst_at_beat = 0; epoch++;
      exp_beats.delete(); exp_addr0.delete(); exp_addr1.delete();
      beats_line = 0;
    end
  endtask

  // One clock: DRAM pushes a word, FIFO/status inputs are driven, then outputs are checked
  task automatic tick();
    logic [127:0] w;
    @(negedge cmd_clk);
    cyc++;
    if (rst_hold > 0) rst_hold--;
    mem_rst = (rst_hold > 0);
    calib_done = calib_cfg;
    if (gen_left > 0) begin
      w = {32'(gen_epoch), 32'(gen_cmd), 32'(gen_idx), $urandom};
      fifo.push_back(w);
      if (gen_epoch == epoch) exp_beats.push_back(w);
      gen_idx++;
      gen_left--;
    end
    ofull    = ofull_mode ? ((cyc / 3) % 2 == 1) : 1'b0;
    rd_empty = (fifo.size() == 0);
    rd_data  = rd_empty ? 128'd0 : fifo[0];
    rd_full  = (fifo.size() >= 64);
    rd_count = (fifo.size() > 127) ? 7'd127 : 7'(fifo.size());
    #1;
    compare();
  endtask

  task automatic issue_req(input int rline, input int sel);
    for (int h = 0; h < 2; h++) begin
      exp_addr0.push_back(model_addr(sel, rline, h, 0, 0));
      exp_addr1.push_back(model_addr(sel, rline, h, HS1, VS1));
    end
    req = 1'b1; req_line = 11'(rline); req_sel = 2'(sel);
    tick();
    req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start = done_count;
    int n = 0;
    while (done_count == start && n < 3000) begin tick(); n++; end
    check(done_count == start + 1, name, done_count - start, 1);
  endtask

  task automatic wait_beats(input int target, input string name);
    int n = 0;
    while (beats_line < target && n < 3000) begin tick(); n++; end
    check(beats_line == target, name, beats_line, target);
  endtask

  initial begin
    int start_cmd;
    int start_done;
    int n;
    logic [29:0] a;
    mem_rst = 1'b1; rst_hold = 4; calib_done = 1'b1; cmd_full = 1'b0; cmd_empty = 1'b1;
    req = 1'b0; req_line = 11'd0; req_sel = 2'd0; arb_state = 2'b01; ofull = 1'b0;
    rd_empty = 1'b1; rd_full = 1'b0; rd_count = 7'd0; rd_data = 128'd0;
    repeat (5) tick();

    check(addr0 == 30'd0 && addr1 == 30'd0, "reset_addr", addr0, 0);
    check({cmd_en0, done0, rd_en0, ovalid0} == 4'd0, "reset_strobes", {cmd_en0, done0, rd_en0, ovalid0}, 0);
`ifdef RD_MEM_DEBUG_EN
    check(debug0 == 8'b0100_0000, "reset_debug", debug0, 8'b0100_0000);
`else
    check(debug0 == 8'd0, "reset_debug", debug0, 0);
`endif

    // Basic line: frame select 1, line 5
    log0.delete(); log1.delete();
    issue_req(5, 0);
    wait_done("line5_done");
    check(log0.size() == 2, "line5_cmds", log0.size(), 2);
    if (log0.size() == 2) begin
      check(log0[0] == 30'h0100_A000, "line5_addr_h0", log0[0], 30'h0100_A000);
      check(log0[1] == 30'h0100_A400, "line5_addr_h1", log0[1], 30'h0100_A400);
      check(log1[0] == 30'h0101_0080, "hstart_addr_h0", log1[0], 30'h0101_0080);
      check(log1[1] == 30'h0101_0480, "hstart_addr_h1", log1[1], 30'h0101_0480);
      a = log1[0];
      check(a[12:0] == 13'd128, "hstart_hbyte0", a[12:0], 128);
      a = log1[1];
      check(a[12:0] == 13'd1152, "hstart_hbyte1", a[12:0], 1152);
    end
    repeat (10) tick();
    check(done_count == 1, "done_once", done_count, 1);

    // Backpressure toggling every 3 cycles
    log0.delete(); log1.delete();
    ofull_mode = 1'b1;
    issue_req(100, 1);
    wait_done("ofull_line_done");
    ofull_mode = 1'b0;
    if (log0.size() == 2) begin
      check(log0[0] == 30'h000C_8000, "ofull_addr_h0", log0[0], 30'h000C_8000);
      check(log0[1] == 30'h000C_8400, "ofull_addr_h1", log0[1], 30'h000C_8400);
    end

    // Arbiter grants the writer for 20 cycles
    arb_state = 2'b10;
    start_cmd = cmd_count;
    issue_req(33, 2);
    for (int i = 0; i < 20; i++) begin
      tick();
      check(!cmd_en0, "cmd_en_without_grant", cmd_en0, 0);
    end
    arb_state = 2'b01;
    n = 0;
    while (cmd_count == start_cmd && n < 100) begin tick(); n++; end
    check(cmd_count == start_cmd + 1, "cmd_after_grant", cmd_count - start_cmd, 1);
    wait_done("arb_line_done");

    // Reset at beat 40, then the next request must flush the 24 leftovers
    start_done = done_count;
    flush_pops = 0;
    rst_at_beat = 40;
    issue_req(7, 2);
    n = 0;
    while (rst_at_beat != 0 && n < 1000) begin tick(); n++; end
    check(rst_at_beat == 0, "reset_trigger_reached", rst_at_beat, 0);
    repeat (80) tick();
    check(done_count == start_done, "no_done_after_reset", done_count - start_done, 0);
    check(addr0 == 30'd0, "addr_after_reset", addr0, 0);
    check(fifo.size() == 24, "stale_words_left", fifo.size(), 24);
    check(flush_pops == 0, "no_pops_while_idle", flush_pops, 0);
    issue_req(9, 1);
    wait_done("post_flush_line_done");
    check(flush_pops == 24, "flush_pop_count", flush_pops, 24);

    // Request during RDD is ignored; calib_done low freezes the transfer
    start_cmd = cmd_count;
    start_done = done_count;
    issue_req(20, 0);
    wait_beats(10, "reach_beat10");
    req = 1'b1; req_line = 11'd500; req_sel = 2'd1;
    tick();
    req = 1'b0;
    wait_beats(30, "reach_beat30");
    calib_cfg = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      check(beats_line == 30, "frozen_beats", beats_line, 30);
    end
    calib_cfg = 1'b1;
    wait_done("resume_line_done");
    repeat (40) tick();
    check(cmd_count == start_cmd + 2, "req_in_rdd_ignored", cmd_count - start_cmd, 2);
    check(done_count == start_done + 1, "single_done_after_resume", done_count - start_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
